// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: clear-FSM state
// encoding, default widths and a packed-bus slice extractor.
package regfile_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int SLICE_MAX_W = 64;
    localparam int BUS_MAX_W   = 256;

    typedef enum logic {
        CLR  = 1'b0,
        IDLE = 1'b1
    } clr_state_t;

    // Returns slice k (w bits wide) of a packed bus; callers cast to their width.
    function automatic logic [SLICE_MAX_W-1:0] bus_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int                   w,
        input int                   k
    );
        logic [BUS_MAX_W-1:0] mask;
        logic [BUS_MAX_W-1:0] shifted;
        mask    = (BUS_MAX_W'(1'b1) << w) - BUS_MAX_W'(1'b1);
        shifted = (bus >> (k * w)) & mask;
        return shifted[SLICE_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: packed read ports, two
// write ports, clear request and status flags.
interface regfile_mp_if #(
    parameter int DATA_W = regfile_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
    parameter int NUM_RD = 2
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     clr_req;
    logic                     busy;
    logic                     wr_drop;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data, clr_req,
        input  rd_data, busy, wr_drop
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data, clr_req,
        output rd_data, busy, wr_drop
    );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on clr_req,
// holding busy high for exactly 2**ADDR_W clock edges.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    clr_state_t        state_q;
    clr_state_t        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // State and pointer registers; reset lands in CLR so the array is swept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR;
            ptr_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic; a request seen while sweeping does not restart it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLR: begin
                ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLR;
                end
            end
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLR;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLR;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign busy_o     = (state_q == CLR);
    assign clr_we_o   = busy_o;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised
// synchronous writes, optional zero register and a hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic                     busy_s;
    logic                     clr_we_s;
    logic [ADDR_W-1:0]        clr_addr_s;
    logic                     wr0_ok_s;
    logic                     wr1_ok_s;
    logic                     wr_drop_d;
    logic                     wr_drop_q;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0]        rd_addr_s [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_s;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req_i  (bus.clr_req),
        .busy_o     (busy_s),
        .clr_we_o   (clr_we_s),
        .clr_addr_o (clr_addr_s)
    );

    // Qualify user writes: blocked while sweeping, entry 0 discarded when
    // hardwired, and wr0 suppressed when wr1 targets the same entry.
    always_comb begin
        wr0_ok_s = 1'b0;
        wr1_ok_s = 1'b0;
        if (!busy_s) begin
            wr1_ok_s = bus.wr1_en &&
                       !((ZERO_REG == 1) && (bus.wr1_addr == {ADDR_W{1'b0}}));
            wr0_ok_s = bus.wr0_en &&
                       !((ZERO_REG == 1) && (bus.wr0_addr == {ADDR_W{1'b0}})) &&
                       !(bus.wr1_en && (bus.wr1_addr == bus.wr0_addr));
        end else begin
            wr0_ok_s = 1'b0;
            wr1_ok_s = 1'b0;
        end
    end

    // A write offered during the sweep is lost; flag it one cycle later.
    always_comb begin
        wr_drop_d = 1'b0;
        if (busy_s && (bus.wr0_en || bus.wr1_en)) begin
            wr_drop_d = 1'b1;
        end else begin
            wr_drop_d = 1'b0;
        end
    end

    // Drop flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next array contents: clear sweep first, then wr1, then wr0.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_we_s && (clr_addr_s == ADDR_W'(i))) begin
                mem_d[i] = {DATA_W{1'b0}};
            end else if (wr1_ok_s && (bus.wr1_addr == ADDR_W'(i))) begin
                mem_d[i] = bus.wr1_data;
            end else if (wr0_ok_s && (bus.wr0_addr == ADDR_W'(i))) begin
                mem_d[i] = bus.wr0_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Storage array; contents are defined only by the clear sweep.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Unpack the read address bus.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s[k] = ADDR_W'(bus_slice(BUS_MAX_W'(bus.rd_addr), ADDR_W, k));
        end
    end

    // Read ports: forced to zero while sweeping and for a hardwired entry 0.
    always_comb begin
        rd_data_s = {(NUM_RD*DATA_W){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (busy_s) begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if ((ZERO_REG == 1) && (rd_addr_s[k] == {ADDR_W{1'b0}})) begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
            end else if (wr1_ok_s && (bus.wr1_addr == rd_addr_s[k])) begin
                rd_data_s[k*DATA_W +: DATA_W] = bus.wr1_data;
            end else if (wr0_ok_s && (bus.wr0_addr == rd_addr_s[k])) begin
                rd_data_s[k*DATA_W +: DATA_W] = bus.wr0_data;
`endif
            end else begin
                rd_data_s[k*DATA_W +: DATA_W] = mem_q[rd_addr_s[k]];
            end
        end
    end

    assign bus.rd_data = rd_data_s;
    assign bus.busy    = busy_s;
    assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (ZERO_REG=1 and 0) driven
// identically and compared against an array-and-countdown reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [31:0]      ph;
        logic [3:0][31:0] rd;
        logic             busy;
        logic             drop;
    } exp_t;

    logic clk   = 1'b1;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_z ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_n ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_z)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    // Reference model: entry values per instance, edges left in the sweep.
    logic [31:0] m_mem [2][DEPTH];
    int          m_cnt  = DEPTH;
    logic        m_drop = 1'b0;

    exp_t sb [$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp,
                       input logic [31:0] ph);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s phase=%0d t=%0t got=%h exp=%h", nm, ph, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int inst, input logic [4:0] a,
                                           input logic w0e, input logic [4:0] w0a,
                                           input logic [31:0] w0d, input logic w1e,
                                           input logic [4:0] w1a, input logic [31:0] w1d);
        if (m_cnt > 0) return 32'h0;
        if (inst == 0 && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (w1e && w1a == a) return w1d;
        if (w0e && w0a == a) return w0d;
`endif
        return m_mem[inst][a];
    endfunction

    // One clock cycle: drive both DUTs, queue the expectation, advance the model.
    task automatic cycle(input logic rstn,
                         input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                         input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                         input logic clr, input logic [4:0] ra0, input logic [4:0] ra1,
                         input int ph);
        exp_t e;
        logic nd;
        rst_n          = rstn;
        bus_z.rd_addr  = {ra1, ra0};   bus_n.rd_addr  = {ra1, ra0};
        bus_z.wr0_en   = w0e;          bus_n.wr0_en   = w0e;
        bus_z.wr0_addr = w0a;          bus_n.wr0_addr = w0a;
        bus_z.wr0_data = w0d;          bus_n.wr0_data = w0d;
        bus_z.wr1_en   = w1e;          bus_n.wr1_en   = w1e;
        bus_z.wr1_addr = w1a;          bus_n.wr1_addr = w1a;
        bus_z.wr1_data = w1d;          bus_n.wr1_data = w1d;
        bus_z.clr_req  = clr;          bus_n.clr_req  = clr;
        if (!rstn) begin
            m_cnt  = DEPTH;
            m_drop = 1'b0;
        end
        e.ph   = 32'(ph);
        e.busy = (m_cnt > 0);
        e.drop = m_drop;
        for (int inst = 0; inst < 2; inst++) begin
            e.rd[inst*2]   = m_read(inst, ra0, w0e, w0a, w0d, w1e, w1a, w1d);
            e.rd[inst*2+1] = m_read(inst, ra1, w0e, w0a, w0d, w1e, w1a, w1d);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rstn) begin
            nd = (m_cnt > 0) && (w0e || w1e);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    for (int inst = 0; inst < 2; inst++)
                        for (int i = 0; i < DEPTH; i++) m_mem[inst][i] = 32'h0;
                end
            end else begin
                for (int inst = 0; inst < 2; inst++) begin
                    if (w0e && !(inst == 0 && w0a == 5'd0)) m_mem[inst][w0a] = w0d;
                    if (w1e && !(inst == 0 && w1a == 5'd0)) m_mem[inst][w1a] = w1d;
                end
                if (clr) m_cnt = DEPTH;
            end
            m_drop = nd;
        end
    endtask

    task automatic rd_cycle(input logic [4:0] ra0, input logic [4:0] ra1, input int ph);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, ra0, ra1, ph);
    endtask

    task automatic rd_all(input int ph);
        for (int a = 0; a < DEPTH; a += 2) rd_cycle(5'(a), 5'(a + 1), ph);
    endtask

    // Monitor: outputs are settled mid-cycle; compare against the queued entry.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            for (int p = 0; p < NR; p++) begin
                cmp("rd_zero_reg", bus_z.rd_data[p*32 +: 32], mon_e.rd[p], mon_e.ph);
                cmp("rd_no_zero_reg", bus_n.rd_data[p*32 +: 32], mon_e.rd[2+p], mon_e.ph);
            end
            cmp("busy", {31'h0, bus_z.busy}, {31'h0, mon_e.busy}, mon_e.ph);
            cmp("busy_nz", {31'h0, bus_n.busy}, {31'h0, mon_e.busy}, mon_e.ph);
            cmp("wr_drop", {31'h0, bus_z.wr_drop}, {31'h0, mon_e.drop}, mon_e.ph);
            cmp("wr_drop_nz", {31'h0, bus_n.wr_drop}, {31'h0, mon_e.drop}, mon_e.ph);
        end
    end

    initial begin
        for (int inst = 0; inst < 2; inst++)
            for (int i = 0; i < DEPTH; i++) m_mem[inst][i] = 32'h0;

        // Reset held, then release and watch the sweep plus a late write.
        for (int c = 0; c < 3; c++)
            cycle(1'b0, 1'b1, 5'd2, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
        for (int c = 0; c < 32; c++)
            cycle(1'b1, (c == 31), 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2);
        cycle(1'b1, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd8, 3);
        rd_cycle(5'd7, 5'd8, 3);
        rd_all(4);

        // Basic write/read.
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5);
        rd_cycle(5'd5, 5'd5, 5);

        // Collision: wr1 wins, no drop.
        cycle(1'b1, 1'b1, 5'd9, 32'h11111111, 1'b1, 5'd9, 32'h22222222, 1'b0, 5'd9, 5'd5, 6);
        rd_cycle(5'd9, 5'd9, 6);

        // Entry 0 write.
        cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 7);
        rd_cycle(5'd0, 5'd0, 7);

        // Same-cycle write and read of r3.
        cycle(1'b1, 1'b1, 5'd3, 32'h00001234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 8);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd3, 5'd3, 8);
        rd_cycle(5'd3, 5'd3, 8);

        // Fill r1..r31 with their index, then clear with a second ignored request.
        for (int i = 1; i < DEPTH; i += 2)
            cycle(1'b1, 1'b1, 5'(i), 32'(i), (i < 31), 5'(i + 1), 32'(i + 1), 1'b0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 9);
        rd_all(9);
        cycle(1'b1, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd6, 10);
        for (int c = 0; c < 9; c++)
            rd_cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 10);
        cycle(1'b1, 1'b1, 5'd6, 32'h6666, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd4, 10);
        for (int c = 0; c < 24; c++)
            rd_cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 10);
        rd_all(10);

        // Reset mid-sweep restarts it from the beginning.
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, 11);
        for (int c = 0; c < 5; c++) rd_cycle(5'd1, 5'd2, 11);
        for (int c = 0; c < 2; c++) cycle(1'b0, 1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2, 11);
        for (int c = 0; c < 34; c++)
            cycle(1'b1, (c >= 30), 5'd12, 32'(c), 1'b0, 5'd0, 32'h0, 1'b0, 5'd12, 5'd0, 11);

        // Randomised traffic over a narrow address window to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] hi;
            hi = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            cycle(($urandom_range(0, 199) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)), $urandom,
                  ($urandom_range(0, 63) == 0),
                  5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)), 12);
        end
        for (int c = 0; c < 34; c++) rd_cycle(5'(c % 32), 5'((c + 7) % 32), 13);

        @(negedge clk);
        #1;
        cmp("sb_drained", 32'(sb.size()), 32'h0, 32'd14);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
